// File: rtl/collision_monitor_if.sv
// Pixel-stream and game-status bundle between the draw modules and collision_monitor.
// Handshake: pixelTick is a one-cycle valid strobe with no ready; coordinates and flags are only meaningful in its cycle.
interface collision_monitor_if;
  logic        pixelTick;
  logic [9:0]  vgaX;
  logic [8:0]  vgaY;
  logic        dinoInGrey;
  logic        obsInGrey;
  logic        startPulse;
  logic [1:0]  gameState;
  logic        hitPulse;
  logic        restartPulse;
  logic [15:0] overlapCount;
  logic [9:0]  hitX;
  logic [8:0]  hitY;

  modport master (
    output pixelTick, vgaX, vgaY, dinoInGrey, obsInGrey, startPulse,
    input  gameState, hitPulse, restartPulse, overlapCount, hitX, hitY
  );

  modport slave (
    input  pixelTick, vgaX, vgaY, dinoInGrey, obsInGrey, startPulse,
    output gameState, hitPulse, restartPulse, overlapCount, hitX, hitY
  );
endinterface

// File: rtl/collision_monitor.sv
// Counts dino/obstacle overlap pixels per frame and runs the IDLE/RUN/HIT/OVER game FSM.
// Optional COLLISION_CAPTURE_EN adds first-overlap coordinate capture on hitX/hitY.
module collision_monitor #(
  parameter int unsigned ScreenW     = 640,
  parameter int unsigned ScreenH     = 480,
  parameter int unsigned THRESH      = 4,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  collision_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10,
    OVER = 2'b11
  } state_t;

  state_t      state;
  logic [15:0] count;
  logic [15:0] last_count;
  logic [15:0] next_count;
  logic [7:0]  hold;
  logic [7:0]  hold_next;
  logic        hit_pulse;
  logic        restart_pulse;
  logic        qual;
  logic        ovl;
  logic        frame_end;
  logic        go_hit;
  logic        go_restart;

  always_comb begin
    qual       = bus.pixelTick && (32'(bus.vgaX) < ScreenW) && (32'(bus.vgaY) < ScreenH);
    ovl        = qual && bus.dinoInGrey && bus.obsInGrey;
    frame_end  = qual && (32'(bus.vgaX) == ScreenW - 1) && (32'(bus.vgaY) == ScreenH - 1);
    // Only RUN frames accumulate; the frame-end pixel itself is included here.
    next_count = (ovl && (state == RUN) && (count != 16'hFFFF)) ? count + 16'd1 : count;
    hold_next  = hold + 8'd1;
    go_hit     = (state == RUN) && frame_end && (next_count >= 16'(THRESH));
    go_restart = (state == OVER) && bus.startPulse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      last_count    <= '0;
      hold          <= '0;
      hit_pulse     <= 1'b0;
      restart_pulse <= 1'b0;
    end else begin
      hit_pulse     <= 1'b0;
      restart_pulse <= 1'b0;
      if (frame_end) begin
        count      <= '0;
        last_count <= next_count;
      end else begin
        count      <= next_count;
      end
      case (state)
        IDLE: if (bus.startPulse) state <= RUN;
        RUN: begin
          if (go_hit) begin
            state     <= HIT;
            hit_pulse <= 1'b1;
            hold      <= '0;
          end
        end
        HIT: begin
          if (frame_end) begin
            hold <= hold_next;
            if (hold_next == 8'(HOLD_FRAMES)) state <= OVER;
          end
        end
        OVER: begin
          if (go_restart) begin
            state         <= RUN;
            restart_pulse <= 1'b1;
            count         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gameState    = state;
  assign bus.hitPulse     = hit_pulse;
  assign bus.restartPulse = restart_pulse;
  assign bus.overlapCount = last_count;

`ifdef COLLISION_CAPTURE_EN
  logic       cap_valid;
  logic [9:0] cap_x;
  logic [8:0] cap_y;
  logic [9:0] hit_x;
  logic [8:0] hit_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_x     <= '0;
      cap_y     <= '0;
      hit_x     <= '0;
      hit_y     <= '0;
    end else begin
      if (frame_end || (state != RUN)) begin
        cap_valid <= 1'b0;
      end else if (ovl && !cap_valid) begin
        cap_valid <= 1'b1;
        cap_x     <= bus.vgaX;
        cap_y     <= bus.vgaY;
      end
      // With nothing captured yet, the frame-end pixel must be the first overlap.
      if (go_hit) begin
        hit_x <= cap_valid ? cap_x : bus.vgaX;
        hit_y <= cap_valid ? cap_y : bus.vgaY;
      end else if (go_restart) begin
        hit_x <= '0;
        hit_y <= '0;
      end
    end
  end

  assign bus.hitX = hit_x;
  assign bus.hitY = hit_y;
`else
  assign bus.hitX = '0;
  assign bus.hitY = '0;
`endif

endmodule

// File: tb/tb_collision_monitor.sv
// Directed bench for collision_monitor with THRESH=4 and HOLD_FRAMES=2.
module tb_collision_monitor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef COLLISION_CAPTURE_EN
  localparam bit Cap = 1'b1;
`else
  localparam bit Cap = 1'b0;
`endif

  collision_monitor_if bus ();

  collision_monitor #(
    .ScreenW(640), .ScreenH(480), .THRESH(4), .HOLD_FRAMES(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one pixel for one cycle; returns at the following negedge.
  task automatic pix(input logic [9:0] x, input logic [8:0] y, input logic d, input logic o,
                     input logic s);
    @(negedge clk);
    bus.pixelTick  = 1'b1;
    bus.vgaX       = x;
    bus.vgaY       = y;
    bus.dinoInGrey = d;
    bus.obsInGrey  = o;
    bus.startPulse = s;
    @(negedge clk);
    bus.pixelTick  = 1'b0;
    bus.dinoInGrey = 1'b0;
    bus.obsInGrey  = 1'b0;
    bus.startPulse = 1'b0;
  endtask

  task automatic start();
    @(negedge clk);
    bus.startPulse = 1'b1;
    @(negedge clk);
    bus.startPulse = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.pixelTick = 1'b0;
    bus.vgaX = '0;
    bus.vgaY = '0;
    bus.dinoInGrey = 1'b0;
    bus.obsInGrey = 1'b0;
    bus.startPulse = 1'b0;
    #12;
    chk("rst_state", 32'(bus.gameState), 0);
    chk("rst_hitpulse", 32'(bus.hitPulse), 0);
    chk("rst_restart", 32'(bus.restartPulse), 0);
    chk("rst_count", 32'(bus.overlapCount), 0);
    chk("rst_hitx", 32'(bus.hitX), 0);
    chk("rst_hity", 32'(bus.hitY), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start();
    chk("start_state", 32'(bus.gameState), 1);
    chk("start_count", 32'(bus.overlapCount), 0);

    // Frame A: three overlaps, plus pixels that must not count.
    pix(10'd10, 9'd20, 1'b1, 1'b1, 1'b0);
    pix(10'd11, 9'd20, 1'b1, 1'b1, 1'b1);
    chk("run_start_ignored", 32'(bus.gameState), 1);
    pix(10'd12, 9'd21, 1'b1, 1'b1, 1'b0);
    pix(10'd13, 9'd21, 1'b1, 1'b0, 1'b0);
    pix(10'd14, 9'd21, 1'b0, 1'b1, 1'b0);
    pix(10'd700, 9'd10, 1'b1, 1'b1, 1'b0);
    pix(10'd639, 9'd479, 1'b0, 1'b0, 1'b0);
    chk("a_count", 32'(bus.overlapCount), 3);
    chk("a_state", 32'(bus.gameState), 1);
    chk("a_hitpulse", 32'(bus.hitPulse), 0);

    // Frame B: three overlaps plus an overlapping frame-end pixel reaches THRESH.
    pix(10'd100, 9'd50, 1'b1, 1'b1, 1'b0);
    pix(10'd101, 9'd50, 1'b1, 1'b1, 1'b0);
    pix(10'd5, 9'd60, 1'b1, 1'b1, 1'b0);
    chk("b_mid_count", 32'(bus.overlapCount), 3);
    pix(10'd639, 9'd479, 1'b1, 1'b1, 1'b0);
    chk("b_count", 32'(bus.overlapCount), 4);
    chk("b_state", 32'(bus.gameState), 2);
    chk("b_hitpulse", 32'(bus.hitPulse), 1);
    chk("b_hitx", 32'(bus.hitX), Cap ? 100 : 0);
    chk("b_hity", 32'(bus.hitY), Cap ? 50 : 0);
    @(negedge clk);
    chk("b_hitpulse_width", 32'(bus.hitPulse), 0);

    // HIT holds for two frame ends; startPulse is ignored meanwhile.
    start();
    chk("hit_start_ignored", 32'(bus.gameState), 2);
    pix(10'd639, 9'd479, 1'b0, 1'b0, 1'b0);
    chk("hit_frame1_state", 32'(bus.gameState), 2);
    chk("hit_frame1_count", 32'(bus.overlapCount), 0);
    chk("hit_hold_hitx", 32'(bus.hitX), Cap ? 100 : 0);
    pix(10'd639, 9'd479, 1'b0, 1'b0, 1'b0);
    chk("hit_frame2_state", 32'(bus.gameState), 3);

    // OVER: restart.
    start();
    chk("restart_state", 32'(bus.gameState), 1);
    chk("restart_pulse", 32'(bus.restartPulse), 1);
    chk("restart_hitx", 32'(bus.hitX), 0);
    chk("restart_hity", 32'(bus.hitY), 0);
    @(negedge clk);
    chk("restart_pulse_width", 32'(bus.restartPulse), 0);

    // One RUN frame with two overlaps, then an asynchronous reset mid-frame.
    pix(10'd0, 9'd0, 1'b1, 1'b1, 1'b0);
    pix(10'd1, 9'd0, 1'b1, 1'b1, 1'b0);
    pix(10'd639, 9'd479, 1'b0, 1'b0, 1'b0);
    chk("c_count", 32'(bus.overlapCount), 2);
    chk("c_state", 32'(bus.gameState), 1);
    pix(10'd3, 9'd3, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(bus.gameState), 0);
    chk("async_count", 32'(bus.overlapCount), 0);
    chk("async_hitpulse", 32'(bus.hitPulse), 0);
    chk("async_restart", 32'(bus.restartPulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // startPulse on an overlapping frame-end pixel in IDLE: frame discarded.
    pix(10'd639, 9'd479, 1'b1, 1'b1, 1'b1);
    chk("idle_fe_state", 32'(bus.gameState), 1);
    chk("idle_fe_count", 32'(bus.overlapCount), 0);
    pix(10'd200, 9'd100, 1'b1, 1'b1, 1'b0);
    pix(10'd639, 9'd479, 1'b0, 1'b0, 1'b0);
    chk("d_count", 32'(bus.overlapCount), 1);
    chk("d_state", 32'(bus.gameState), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
